fetch_stage: RTL and testbench

// - IF stage of the Antares pipeline. Owns the PC register, fetches from instruction memory over a req/ready + rvalid handshake, and loads the IF/ID pipeline register.
// - pc drives pc_control.PC; pc_control.nextPC returns as next_pc. stall comes from the hazard unit; flush is asserted by ID on taken branch or jumpReg.
// - Tolerates multi-cycle imem latency. At most one request is outstanding.

---
 rtl/antares_pkg.sv | 31 +++
 rtl/fetch_stage_if.sv | 36 +++
 rtl/if_id_reg.sv | 51 +++++
 rtl/fetch_stage.sv | 135 +++++++++++++
 tb/tb_fetch_stage.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/antares_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : antares_pkg
//  Description : Shared definitions for the Antares pipeline front end:
//                reset PC, bubble instruction word, fetch FSM state encoding
//                and the PC increment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package antares_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // FETCH : request on the bus, waiting for acceptance
    // WAIT  : request accepted, waiting for the response
    // HOLD  : response captured while stalled, waiting for stall release
    // DROP  : waiting for the response of a squashed request
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

    // Sequential PC; wraps modulo 2^32 by construction.
    function automatic logic [31:0] pc_plus4(input logic [31:0] p);
        return p + 32'd4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_if
//  Description : Instruction memory bus. Request side is req/addr with a
//                ready acceptance; response side is rvalid/rdata, arriving
//                at least one cycle after acceptance.
//  Ports       : master - fetch unit (drives req, addr)
//                slave  - instruction memory (drives ready, rvalid, rdata)
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;

    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rvalid,
        output rdata
    );

endinterface
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : IF/ID pipeline register holding {valid, instr, pc4}.
//                A bubble clears valid and writes NOP_INSTR while keeping
//                pc4; a load writes a real instruction. Bubble wins.
//  Ports       : clk, i_reset_n          - clock, synchronous active-low reset
//                i_load, i_bubble        - write enables from the fetch FSM
//                i_instr, i_pc4          - data for a load
//                o_valid, o_instr, o_pc4 - register contents
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  wire logic        clk,
    input  wire logic        i_reset_n,
    input  wire logic        i_load,
    input  wire logic        i_bubble,
    input  wire logic [31:0] i_instr,
    input  wire logic [31:0] i_pc4,
    output logic             o_valid,
    output logic [31:0]      o_instr,
    output logic [31:0]      o_pc4
);

    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'h0000_0000;
        end else if (i_bubble) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : IF stage of the Antares pipeline. Owns the PC, fetches one
//                instruction at a time over the imem bus (at most one request
//                outstanding, any response latency) and loads IF/ID.
//  Ports       : clk, reset_n     - clock, synchronous active-low reset
//                next_pc          - next PC from pc_control
//                stall            - hold IF/ID and PC (hazard unit)
//                flush            - squash current fetch, redirect to next_pc
//                pc               - current fetch PC
//                imem             - instruction memory bus (master side)
//                if_id_valid/instr/pc4 - IF/ID pipeline register
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = antares_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = antares_pkg::NOP_INSTR
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    input  wire logic [31:0] next_pc,
    input  wire logic        stall,
    input  wire logic        flush,
    output logic [31:0]      pc,
    fetch_stage_if.master    imem,
    output logic             if_id_valid,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc4
);

    import antares_pkg::*;

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic [31:0]  r_hold;
    logic [31:0]  w_hold_nxt;
    logic         w_load;
    logic         w_bubble;
    logic [31:0]  w_load_instr;

    // The request is masked during the reset cycle so that memory never
    // accepts a fetch the FSM is about to forget.
    assign imem.req  = (r_state == FETCH) && reset_n;
    assign imem.addr = r_pc;
    assign pc        = r_pc;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
            r_hold  <= 32'h0000_0000;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_hold_nxt   = r_hold;
        w_load       = 1'b0;
        w_bubble     = 1'b0;
        w_load_instr = imem.rdata;

        if (flush) begin
            w_bubble = 1'b1;
            w_pc_nxt = next_pc;
            case (r_state)
                // A request accepted in the flush cycle is already in
                // flight; its response must still be absorbed.
                FETCH:   w_state_nxt = imem.ready  ? DROP  : FETCH;
                WAIT:    w_state_nxt = imem.rvalid ? FETCH : DROP;
                HOLD:    w_state_nxt = FETCH;
                DROP:    w_state_nxt = imem.rvalid ? FETCH : DROP;
                default: w_state_nxt = FETCH;
            endcase
        end else begin
            case (r_state)
                FETCH: begin
                    // Stall does not block issuing; only consumption waits.
                    if (imem.ready) begin
                        w_state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (imem.rvalid) begin
                        if (stall) begin
                            w_hold_nxt  = imem.rdata;
                            w_state_nxt = HOLD;
                        end else begin
                            w_load      = 1'b1;
                            w_pc_nxt    = next_pc;
                            w_state_nxt = FETCH;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        w_load       = 1'b1;
                        w_load_instr = r_hold;
                        w_pc_nxt     = next_pc;
                        w_state_nxt  = FETCH;
                    end
                end
                DROP: begin
                    if (imem.rvalid) begin
                        w_state_nxt = FETCH;
                    end
                end
                default: w_state_nxt = FETCH;
            endcase
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk       (clk),
        .i_reset_n (reset_n),
        .i_load    (w_load),
        .i_bubble  (w_bubble),
        .i_instr   (w_load_instr),
        .i_pc4     (pc_plus4(r_pc)),
        .o_valid   (if_id_valid),
        .o_instr   (if_id_instr),
        .o_pc4     (if_id_pc4)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage. An imem model serves
//                mem[i] = 32'h1000_0000 + i with configurable ready delay
//                and response latency; a transaction-level reference model
//                predicts PC, request and IF/ID after each clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    import antares_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        flush;
    logic [31:0] next_pc;
    logic [31:0] pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;

    always #5 clk = ~clk;

    fetch_stage_if imem ();

    fetch_stage dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .next_pc     (next_pc),
        .stall       (stall),
        .flush       (flush),
        .pc          (pc),
        .imem        (imem),
        .if_id_valid (if_id_valid),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4)
    );

    typedef struct {
        logic [31:0] pc;
        logic        req;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // Reference model: one outstanding fetch at most.
    // busy   - a request was accepted and its response has not returned
    // squash - that outstanding response belongs to a flushed fetch
    // held   - a response arrived during stall and waits for release
    logic [31:0] m_pc, m_instr, m_pc4, m_hbuf;
    logic        m_valid, m_busy, m_squash, m_held;

    // Instruction memory model
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          rdy_wait;
    int          g_lat, g_rdy;
    logic        g_rand;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    task automatic model_step(input logic rn, input logic st, input logic fl,
                              input logic rdy, input logic rv, input logic [31:0] rd,
                              input logic [31:0] npc);
        logic acc, resp;
        if (!rn) begin
            m_pc = RESET_PC; m_valid = 1'b0; m_instr = NOP_INSTR; m_pc4 = 32'h0;
            m_busy = 1'b0; m_squash = 1'b0; m_held = 1'b0; m_hbuf = 32'h0;
        end else begin
            acc  = !m_busy && !m_held && rdy;
            resp = m_busy && rv;
            if (fl) begin
                m_valid = 1'b0;
                m_instr = NOP_INSTR;
                m_pc    = npc;
                m_held  = 1'b0;
                if (acc) begin
                    m_busy = 1'b1; m_squash = 1'b1;
                end else if (resp) begin
                    m_busy = 1'b0; m_squash = 1'b0;
                end else if (m_busy) begin
                    m_squash = 1'b1;
                end
            end else if (acc) begin
                m_busy = 1'b1;
            end else if (resp) begin
                m_busy = 1'b0;
                if (m_squash) begin
                    m_squash = 1'b0;
                end else if (st) begin
                    m_held = 1'b1; m_hbuf = rd;
                end else begin
                    m_valid = 1'b1; m_instr = rd; m_pc4 = m_pc + 32'd4; m_pc = npc;
                end
            end else if (m_held && !st) begin
                m_held = 1'b0;
                m_valid = 1'b1; m_instr = m_hbuf; m_pc4 = m_pc + 32'd4; m_pc = npc;
            end
        end
        exp_q.push_back('{pc: m_pc, req: !m_busy && !m_held, valid: m_valid,
                          instr: m_instr, pc4: m_pc4});
    endtask

    // One clock cycle of stimulus: drive inputs after the falling edge,
    // let the imem model react to the DUT request, then record expectations.
    task automatic step(input logic rn, input logic st, input logic fl,
                        input logic redir, input logic [31:0] tgt);
        logic rv, rdy, idle;
        @(negedge clk);
        reset_n = rn;
        stall   = st;
        flush   = fl;
        next_pc = redir ? tgt : m_pc + 32'd4;
        idle = !mem_busy;
        rv   = 1'b0;
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                rv = 1'b1;
                mem_busy = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        imem.rvalid = rv;
        imem.rdata  = rv ? (32'h1000_0000 + (mem_addr >> 2)) : $urandom;
        #1;
        rdy = 1'b0;
        if (idle && imem.req) begin
            if (rdy_wait >= g_rdy) rdy = 1'b1;
            else rdy_wait++;
        end
        imem.ready = rdy;
        if (rdy) begin
            mem_busy = 1'b1;
            mem_addr = imem.addr;
            mem_cnt  = g_lat - 1;
            rdy_wait = 0;
            if (g_rand) begin
                g_lat = $urandom_range(1, 4);
                g_rdy = $urandom_range(0, 3);
            end
        end
        model_step(rn, st, fl, rdy, rv, imem.rdata, next_pc);
    endtask

    task automatic run_until_busy(input int bound);
        int n = 0;
        while (!m_busy && n < bound) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
            n++;
        end
        if (!m_busy) begin
            checks++;
            failures++;
            $display("FAIL run_until_busy: got no accepted request within %0d cycles", bound);
        end
    endtask

    // Monitor: compare DUT state with the model after every clock edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pc",          pc,                  e.pc);
            chk("imem_req",    {31'b0, imem.req},   {31'b0, e.req & reset_n});
            chk("imem_addr",   imem.addr,           e.pc);
            chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.valid});
            chk("if_id_instr", if_id_instr,         e.instr);
            chk("if_id_pc4",   if_id_pc4,           e.pc4);
        end
    end

    initial begin
        reset_n = 1'b0; stall = 1'b0; flush = 1'b0; next_pc = 32'h0;
        imem.ready = 1'b0; imem.rvalid = 1'b0; imem.rdata = 32'h0;
        m_pc = RESET_PC; m_valid = 1'b0; m_instr = NOP_INSTR; m_pc4 = 32'h0;
        m_busy = 1'b0; m_squash = 1'b0; m_held = 1'b0; m_hbuf = 32'h0;
        mem_busy = 1'b0; mem_cnt = 0; mem_addr = 32'h0; rdy_wait = 0;
        g_lat = 1; g_rdy = 0; g_rand = 1'b0;

        // Reset, then three back-to-back fetches (pc4 4, 8, 12)
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // Stall across the response cycle -> HOLD, then release
        run_until_busy(10);
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // Flush while waiting with no response yet -> stale response dropped
        g_lat = 3;
        run_until_busy(10);
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'd20);
        repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // Flush in the same cycle as the response
        g_lat = 1;
        run_until_busy(10);
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'd40);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // Reset while waiting; the late response must be ignored
        g_lat = 3;
        run_until_busy(10);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // PC wrap: fetch at 32'hFFFF_FFFC gives pc4 = 0
        g_lat = 1;
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // Delayed acceptance: address must stay stable
        g_rdy = 3;
        repeat (14) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        g_rdy = 0;

        // Randomized mix of stall, flush, redirect, reset and bus timing
        g_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic rn, st, fl, rd;
            rn = ($urandom_range(0, 49) != 0);
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 9) == 0);
            rd = fl || ($urandom_range(0, 7) == 0);
            step(rn, st, fl, rd, $urandom & 32'hFFFF_FFFC);
        end

        @(negedge clk);
        reset_n = 1'b1; stall = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expectations expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
